imem_port_arbiter: RTL and testbench
====================================

# imem_port_arbiter

Controller that shares the single-port instruction memory between the instruction-fetch stage and a program loader. After reset it optionally holds fetch off while the loader writes the program image (boot phase). It then runs with fetch priority, using a starvation counter so loader writes still complete. The block sits between the fetch stage, the loader/debug interface, and the instruction memory macro, and drives the fetch stall signal.

## Interface
- INSTR_WIDTH, 32, instruction/data word width
- INSTR_MEM_DEPTH, 32, memory depth in words
- STARVE_LIMIT, 4, consecutive denied loader cycles before the loader is forced a grant (≥1)
- MEM_ADDR_WIDTH, $clog2(INSTR_MEM_DEPTH), derived word-index width (not overridable)

- i_clk  in  1  clock
- i_reset_n  in  1  reset; synchronous, active-low; clock i_clk
- i_fetch_req  in  1  fetch wants a read this cycle
- i_fetch_addr  in  MEM_ADDR_WIDTH+2  byte address (PC); word index = addr[MEM_ADDR_WIDTH+1:2]
- o_fetch_gnt  out  1  fetch read issued this cycle
- o_fetch_stall  out  1  i_fetch_req & ~o_fetch_gnt
- o_fetch_rvalid  out  1  read data valid (registered)
- o_fetch_rdata  out  INSTR_WIDTH  read data (pass-through of i_mem_rdata)
- i_ld_valid  in  1  loader write request
- i_ld_addr  in  MEM_ADDR_WIDTH  loader word index
- i_ld_data  in  INSTR_WIDTH  loader write data
- o_ld_ready  out  1  loader write accepted this cycle
- i_boot_done  in  1  single-cycle pulse ending boot phase
- o_mem_en, o_mem_we  out  1 each  memory enable / write enable
- o_mem_addr  out  MEM_ADDR_WIDTH  memory word index
- o_mem_wdata  out  INSTR_WIDTH  memory write data
- i_mem_rdata  in  INSTR_WIDTH  memory read data, 1-cycle latency

## Operation
- State machine: BOOT, RUN. Reset state BOOT (see Configuration). BOOT→RUN when i_boot_done=1. RUN is terminal until reset.
- BOOT: o_fetch_gnt=0 always. Any i_ld_valid is accepted (o_ld_ready=1).
- RUN arbitration, per cycle:
  - Only fetch requests: fetch granted.
  - Only loader requests: loader granted.
  - Both request: fetch granted unless starve_cnt==STARVE_LIMIT, in which case loader granted.
- starve_cnt: increments (saturating at STARVE_LIMIT) each RUN cycle where i_ld_valid=1 and o_ld_ready=0. Clears on any loader grant or when i_ld_valid=0.
- Memory port, driven combinationally from the winner:
  - Fetch grant: en=1, we=0, addr=fetch word index.
  - Loader grant: en=1, we=1, addr=i_ld_addr, wdata=i_ld_data.
  - No grant: en=0, we=0.
- Misaligned fetch address (low 2 bits ≠ 0): low bits are ignored. No error is raised.
- Loader handshake: a transfer occurs when i_ld_valid & o_ld_ready. The loader holds addr/data stable until ready. o_ld_ready may be 1 only while i_ld_valid=1.
- Ignored inputs:
  - i_boot_done in RUN.
  - i_fetch_req in BOOT. o_fetch_stall=1 if asserted.

## Timing
- Grant and memory-port outputs are combinational in the same cycle as the request.
- o_fetch_rvalid is registered as o_fetch_gnt delayed one cycle. o_fetch_rdata is valid in that cycle only.
- Back-to-back fetch grants give one rvalid per cycle, with no bubbles.
- A loader write is visible to a fetch of the same address granted the following cycle or later.
- Reset values: state=BOOT (RUN without macro), starve_cnt=0, o_fetch_rvalid=0. All combinational outputs are 0 while in reset. o_fetch_rdata follows i_mem_rdata.
- Reset mid-operation: any pending rvalid is dropped (0 the cycle after reset is sampled). A loader write is not granted during reset cycles.
- i_boot_done coinciding with a loader request: the write is accepted under BOOT rules. RUN rules apply from the next cycle.

## Configuration
- IMEM_BOOT_EN defined:
  - Reset enters BOOT.
  - Fetch is stalled until i_boot_done.
- IMEM_BOOT_EN undefined:
  - BOOT state is not built.
  - Reset enters RUN directly.
  - i_boot_done is ignored.
  - Loader writes arbitrate under RUN rules from the first cycle.

## Test plan
- Boot load (IMEM_BOOT_EN): reset, loader writes 0x00100093 to index 0 and 0x00208113 to index 1 while i_fetch_req=1 → o_ld_ready=1 both cycles, o_fetch_gnt=0, o_fetch_stall=1. Pulse i_boot_done; fetch addr 0 → next cycle o_fetch_rvalid=1, rdata=0x00100093.
- Streaming fetch in RUN: fetch addrs 0,4,8 on consecutive cycles → gnt=1 each cycle; rvalid=1 for 3 consecutive cycles starting one cycle later, with data of indices 0,1,2.
- Starvation, STARVE_LIMIT=4: i_fetch_req and i_ld_valid both held high → fetch granted 4 cycles, loader granted in cycle 5 (stall=1 that cycle), starve_cnt back to 0. Pattern repeats with period 5.
- Idle loader slot: i_fetch_req=0, i_ld_valid=1, index 3, data 0xDEADBEEF → same-cycle o_ld_ready=1, mem we=1. Fetch addr 12 next cycle → rdata 0xDEADBEEF.
- Reset mid-read: fetch granted in cycle N, i_reset_n=0 in cycle N+1 → o_fetch_rvalid=0 in cycle N+1 and N+2, state=BOOT, starve_cnt=0.
- Without IMEM_BOOT_EN: fetch request in first cycle after reset → o_fetch_gnt=1 immediately. i_boot_done pulse has no effect.

Source files
------------

// File: rtl/imem_port_arbiter.sv
// Shares the single-port instruction memory between fetch (priority) and a program loader.
// Define IMEM_BOOT_EN to build the BOOT phase that holds fetch off until i_boot_done.
module imem_port_arbiter #(
  parameter int INSTR_WIDTH     = 32,
  parameter int INSTR_MEM_DEPTH = 32,
  parameter int STARVE_LIMIT    = 4,
  localparam int MEM_ADDR_WIDTH = $clog2(INSTR_MEM_DEPTH)
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_fetch_req,
  input  logic [MEM_ADDR_WIDTH+1:0] i_fetch_addr,
  output logic                      o_fetch_gnt,
  output logic                      o_fetch_stall,
  output logic                      o_fetch_rvalid,
  output logic [INSTR_WIDTH-1:0]    o_fetch_rdata,
  input  logic                      i_ld_valid,
  input  logic [MEM_ADDR_WIDTH-1:0] i_ld_addr,
  input  logic [INSTR_WIDTH-1:0]    i_ld_data,
  output logic                      o_ld_ready,
  input  logic                      i_boot_done,
  output logic                      o_mem_en,
  output logic                      o_mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [INSTR_WIDTH-1:0]    o_mem_wdata,
  input  logic [INSTR_WIDTH-1:0]    i_mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

`ifdef IMEM_BOOT_EN
  typedef enum logic {ST_BOOT = 1'b0, ST_RUN = 1'b1} state_e;
  state_e state_q;
`endif

  logic             boot_s;
  logic             fetch_gnt_s;
  logic             ld_gnt_s;
  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;
  logic             rvalid_q;
  logic             unused_s;

`ifdef IMEM_BOOT_EN
  assign boot_s = (state_q == ST_BOOT);
`else
  assign boot_s = 1'b0;
`endif

  // Byte-offset bits of the PC are dropped silently; i_boot_done is unused without BOOT.
  assign unused_s = ^{i_fetch_addr[1:0], i_boot_done};

  // Arbitration: fetch wins ties unless the loader has been denied STARVE_LIMIT times in a row.
  always_comb begin
    fetch_gnt_s = 1'b0;
    ld_gnt_s    = 1'b0;
    if (!i_reset_n) begin
      fetch_gnt_s = 1'b0;
      ld_gnt_s    = 1'b0;
    end else if (boot_s) begin
      fetch_gnt_s = 1'b0;
      ld_gnt_s    = i_ld_valid;
    end else if (i_fetch_req && i_ld_valid) begin
      ld_gnt_s    = (starve_q == CNT_W'(STARVE_LIMIT));
      fetch_gnt_s = ~ld_gnt_s;
    end else begin
      fetch_gnt_s = i_fetch_req;
      ld_gnt_s    = i_ld_valid;
    end
  end

  // Starvation counter next state and memory port steering from the winner.
  always_comb begin
    starve_d    = {CNT_W{1'b0}};
    o_mem_en    = fetch_gnt_s | ld_gnt_s;
    o_mem_we    = ld_gnt_s;
    o_mem_addr  = {MEM_ADDR_WIDTH{1'b0}};
    o_mem_wdata = {INSTR_WIDTH{1'b0}};
    if (!boot_s && i_ld_valid && !ld_gnt_s) begin
      if (starve_q == CNT_W'(STARVE_LIMIT)) starve_d = starve_q;
      else starve_d = starve_q + CNT_W'(1);
    end else begin
      starve_d = {CNT_W{1'b0}};
    end
    if (ld_gnt_s) begin
      o_mem_addr  = i_ld_addr;
      o_mem_wdata = i_ld_data;
    end else if (fetch_gnt_s) begin
      o_mem_addr  = i_fetch_addr[MEM_ADDR_WIDTH+1:2];
    end else begin
      o_mem_addr  = {MEM_ADDR_WIDTH{1'b0}};
    end
  end

  // Phase FSM, starvation counter and read-valid pipeline.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
`ifdef IMEM_BOOT_EN
      state_q <= ST_BOOT;
`endif
      starve_q <= {CNT_W{1'b0}};
      rvalid_q <= 1'b0;
    end else begin
`ifdef IMEM_BOOT_EN
      if (state_q == ST_BOOT && i_boot_done) state_q <= ST_RUN;
      else state_q <= state_q;
`endif
      starve_q <= starve_d;
      rvalid_q <= fetch_gnt_s;
    end
  end

  assign o_fetch_gnt    = fetch_gnt_s;
  assign o_ld_ready     = ld_gnt_s;
  assign o_fetch_stall  = i_reset_n & i_fetch_req & ~fetch_gnt_s;
  // A read in flight when reset arrives is suppressed immediately.
  assign o_fetch_rvalid = rvalid_q & i_reset_n;
  assign o_fetch_rdata  = i_mem_rdata;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed pins plus randomized traffic against a behavioural model.
module tb_imem_port_arbiter;
  localparam int IW = 32, DEPTH = 32, LIMIT = 4, AW = $clog2(DEPTH);
`ifdef IMEM_BOOT_EN
  localparam bit BOOT_EN = 1'b1;
`else
  localparam bit BOOT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, fetch_req, ld_valid, boot_done;
  logic [AW+1:0] fetch_addr;
  logic [AW-1:0] ld_addr, mem_addr;
  logic [IW-1:0] ld_data, mem_wdata, mem_rdata, fetch_rdata;
  logic          fetch_gnt, fetch_stall, fetch_rvalid, ld_ready, mem_en, mem_we;

  imem_port_arbiter #(.INSTR_WIDTH(IW), .INSTR_MEM_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_fetch_req(fetch_req), .i_fetch_addr(fetch_addr),
    .o_fetch_gnt(fetch_gnt), .o_fetch_stall(fetch_stall),
    .o_fetch_rvalid(fetch_rvalid), .o_fetch_rdata(fetch_rdata),
    .i_ld_valid(ld_valid), .i_ld_addr(ld_addr), .i_ld_data(ld_data), .o_ld_ready(ld_ready),
    .i_boot_done(boot_done),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata)
  );

  // Memory macro stand-in: one-cycle read latency.
  logic [IW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  // Behavioural model state
  logic [IW-1:0] ref_mem [DEPTH];
  bit            ref_ok  [DEPTH];
  bit            m_boot, m_rv, m_rknown;
  int            m_denied;
  logic [IW-1:0] m_rdata;

  int passed = 0, total = 0;
  logic last_gnt, last_rdy, last_stall, last_rv, last_we;
  logic [IW-1:0] last_rdata;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cycle();
    logic e_gnt, e_rdy, e_stall, e_rv;
    logic [AW-1:0] widx;
    @(negedge clk);
    widx = fetch_addr[AW+1:2];
    if (!rst_n) begin
      e_gnt = 1'b0; e_rdy = 1'b0;
    end else if (m_boot) begin
      e_gnt = 1'b0; e_rdy = ld_valid;
    end else if (fetch_req && ld_valid) begin
      e_rdy = (m_denied >= LIMIT); e_gnt = ~e_rdy;
    end else begin
      e_gnt = fetch_req; e_rdy = ld_valid;
    end
    e_stall = rst_n & fetch_req & ~e_gnt;
    e_rv    = m_rv & rst_n;
    chk("fetch_gnt", fetch_gnt, e_gnt);
    chk("ld_ready", ld_ready, e_rdy);
    chk("fetch_stall", fetch_stall, e_stall);
    chk("fetch_rvalid", fetch_rvalid, e_rv);
    chk("mem_en", mem_en, e_gnt | e_rdy);
    chk("mem_we", mem_we, e_rdy);
    if (e_gnt) chk("mem_addr_fetch", mem_addr, widx);
    if (e_rdy) begin
      chk("mem_addr_ld", mem_addr, ld_addr);
      chk("mem_wdata", mem_wdata, ld_data);
    end
    if (e_rv && m_rknown) chk("fetch_rdata", fetch_rdata, m_rdata);
    last_gnt = fetch_gnt; last_rdy = ld_ready; last_stall = fetch_stall;
    last_rv = fetch_rvalid; last_rdata = fetch_rdata; last_we = mem_we;
    @(posedge clk);
    if (!rst_n) begin
      m_boot = BOOT_EN; m_denied = 0; m_rv = 1'b0;
    end else begin
      if (e_rdy) begin
        ref_mem[ld_addr] = ld_data; ref_ok[ld_addr] = 1'b1; m_denied = 0;
      end else if (ld_valid && !m_boot) begin
        m_denied = (m_denied < LIMIT) ? m_denied + 1 : LIMIT;
      end else begin
        m_denied = 0;
      end
      m_rv = e_gnt;
      if (e_gnt) begin
        m_rdata = ref_mem[widx]; m_rknown = ref_ok[widx];
      end
      if (m_boot && boot_done) m_boot = 1'b0;
    end
    #1;
  endtask

  task automatic load(input int idx, input logic [IW-1:0] d);
    fetch_req = 1'b0; ld_valid = 1'b1; ld_addr = AW'(idx); ld_data = d;
    cycle();
    chk("pin_load_rdy", last_rdy, 1'b1);
    ld_valid = 1'b0;
  endtask

  initial begin
    logic [9:0] rdy_pat;
    for (int i = 0; i < DEPTH; i++) begin ref_ok[i] = 1'b0; ref_mem[i] = '0; end
    m_boot = BOOT_EN; m_denied = 0; m_rv = 1'b0; m_rknown = 1'b0; m_rdata = '0;
    rst_n = 1'b0; fetch_req = 1'b1; fetch_addr = '0; ld_valid = 1'b1;
    ld_addr = '0; ld_data = 32'h0; boot_done = 1'b0;
    #1;
    repeat (2) cycle();
    chk("pin_reset_gnt", last_gnt, 1'b0);
    chk("pin_reset_rdy", last_rdy, 1'b0);
    chk("pin_reset_rvalid", last_rv, 1'b0);
    rst_n = 1'b1;
    ld_addr = 5'd0; ld_data = 32'h00100093;
`ifdef IMEM_BOOT_EN
    cycle();
    chk("pin_boot_rdy0", last_rdy, 1'b1);
    chk("pin_boot_gnt0", last_gnt, 1'b0);
    chk("pin_boot_stall0", last_stall, 1'b1);
    ld_addr = 5'd1; ld_data = 32'h00208113;
    cycle();
    chk("pin_boot_rdy1", last_rdy, 1'b1);
    chk("pin_boot_stall1", last_stall, 1'b1);
    ld_valid = 1'b0; fetch_req = 1'b0; boot_done = 1'b1;
    cycle();
    boot_done = 1'b0;
`else
    ld_valid = 1'b0; boot_done = 1'b1;
    cycle();
    chk("pin_noboot_gnt_first", last_gnt, 1'b1);
    boot_done = 1'b0;
    load(0, 32'h00100093);
    load(1, 32'h00208113);
`endif
    fetch_req = 1'b1; fetch_addr = 7'd0;
    cycle();
    chk("pin_first_fetch_gnt", last_gnt, 1'b1);
    fetch_req = 1'b0;
    cycle();
    chk("pin_first_fetch_rv", last_rv, 1'b1);
    chk("pin_first_fetch_data", last_rdata, 32'h00100093);

    // Streaming fetch of indices 0,1,2
    load(2, 32'h00308193);
    fetch_req = 1'b1; fetch_addr = 7'd0;
    cycle(); chk("pin_stream_gnt0", last_gnt, 1'b1);
    fetch_addr = 7'd4;
    cycle(); chk("pin_stream_gnt1", last_gnt, 1'b1); chk("pin_stream_d0", last_rdata, 32'h00100093);
    fetch_addr = 7'd8;
    cycle(); chk("pin_stream_gnt2", last_gnt, 1'b1); chk("pin_stream_d1", last_rdata, 32'h00208113);
    fetch_req = 1'b0;
    cycle(); chk("pin_stream_rv2", last_rv, 1'b1); chk("pin_stream_d2", last_rdata, 32'h00308193);

    // Starvation: loader wins every fifth cycle
    fetch_req = 1'b1; fetch_addr = 7'd0; ld_valid = 1'b1; ld_addr = 5'd5; ld_data = 32'h55;
    for (int i = 0; i < 10; i++) begin
      cycle();
      rdy_pat[i] = last_rdy;
    end
    chk("pin_starve_pattern", rdy_pat, 10'b1000010000);
    ld_valid = 1'b0; fetch_req = 1'b0;
    cycle();

    // Idle loader slot, then fetch of the written word (aligned and misaligned)
    ld_valid = 1'b1; ld_addr = 5'd3; ld_data = 32'hDEADBEEF;
    cycle();
    chk("pin_idle_rdy", last_rdy, 1'b1);
    chk("pin_idle_we", last_we, 1'b1);
    ld_valid = 1'b0; fetch_req = 1'b1; fetch_addr = 7'd12;
    cycle(); chk("pin_idle_fetch_gnt", last_gnt, 1'b1);
    fetch_addr = 7'd13;
    cycle(); chk("pin_idle_rdata", last_rdata, 32'hDEADBEEF);
    fetch_req = 1'b0;
    cycle(); chk("pin_misaligned_rdata", last_rdata, 32'hDEADBEEF);

    // Reset mid-read
    fetch_req = 1'b1; fetch_addr = 7'd4;
    cycle(); chk("pin_rst_gnt", last_gnt, 1'b1);
    rst_n = 1'b0; fetch_req = 1'b0;
    cycle(); chk("pin_rst_rv_n1", last_rv, 1'b0);
    rst_n = 1'b1;
    cycle(); chk("pin_rst_rv_n2", last_rv, 1'b0);
    boot_done = 1'b1;
    cycle();
    boot_done = 1'b0;

    // Randomized traffic; loader holds its request until accepted
    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      boot_done = ($urandom_range(0, 19) == 0);
      fetch_req = ($urandom_range(0, 2) != 0);
      fetch_addr = 7'($urandom);
      if (!(ld_valid && !last_rdy)) begin
        ld_valid = ($urandom_range(0, 2) != 0);
        ld_addr  = 5'($urandom);
        ld_data  = $urandom;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
